// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-FSM state type and instruction size
package core_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int ILEN_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch address handshake between pc_gen and the fetch stage
interface pc_gen_if #(
  parameter int XLEN = 64
);
  logic            fetch_valid_o;
  logic            fetch_ready_i;
  logic [XLEN-1:0] pc_o;

  modport master (output fetch_valid_o, output pc_o, input fetch_ready_i);
  modport slave  (input fetch_valid_o, input pc_o, output fetch_ready_i);
endinterface

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - free-running counter that wraps modulo 2^W
module wrap_counter #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with boot/run/halt FSM and perf counters
module pc_gen
  import core_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000),
  parameter int              CNT_W     = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pc_gen_if.master         fetch,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  input  logic             halt_i,
  input  logic             retire_i,
  output logic             misalign_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [1:0]       state_o
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            misalign_q;

  logic            redirect_aligned;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] pc_seq;

  assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign trap_target      = {trap_pc_i[XLEN-1:2], 2'b00};
  assign pc_seq           = pc_q + XLEN'(ILEN_BYTES);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          if (trap_valid_i) pc_q <= trap_target;
          state_q <= ST_RUN;
          valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (trap_valid_i) begin
            pc_q <= trap_target;
          end else if (redirect_valid_i) begin
            // A halt request does not cancel a redirect arriving in the same cycle
            if (redirect_aligned) pc_q <= redirect_pc_i;
            else                  misalign_q <= 1'b1;
            if (halt_i) begin
              state_q <= ST_HALT;
              valid_q <= 1'b0;
            end
          end else if (halt_i) begin
            state_q <= ST_HALT;
            valid_q <= 1'b0;
          end else if (fetch.fetch_ready_i) begin
            pc_q <= pc_seq;
          end
        end
        ST_HALT: begin
          if (trap_valid_i) pc_q <= trap_target;
          if (trap_valid_i || !halt_i) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.fetch_valid_o = valid_q;
  assign fetch.pc_o          = pc_q;
  assign misalign_o          = misalign_q;
  assign state_o             = state_q;

  wrap_counter #(.W(CNT_W)) u_cycle (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (1'b1),
    .cnt_o  (cycle_o)
  );

  wrap_counter #(.W(CNT_W)) u_instret (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (retire_i),
    .cnt_o  (instret_o)
  );

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen (64-bit default and 32-bit/4-bit counter variant)
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        red_v, trap_v, halt, retire, misalign;
  logic [63:0] red_pc, trap_pc, cycle, instret;
  logic [1:0]  state;

  logic        rst32_n;
  logic        red32_v, trap32_v, halt32, retire32, misalign32;
  logic [31:0] red32_pc, trap32_pc;
  logic [3:0]  cycle32, instret32;
  logic [1:0]  state32;

  pc_gen_if #(.XLEN(64)) fif ();
  pc_gen_if #(.XLEN(32)) fif32 ();

  pc_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch(fif),
    .redirect_valid_i(red_v), .redirect_pc_i(red_pc),
    .trap_valid_i(trap_v), .trap_pc_i(trap_pc),
    .halt_i(halt), .retire_i(retire), .misalign_o(misalign),
    .cycle_o(cycle), .instret_o(instret), .state_o(state)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .CNT_W(4)) dut32 (
    .clk_i(clk), .rst_ni(rst32_n), .fetch(fif32),
    .redirect_valid_i(red32_v), .redirect_pc_i(red32_pc),
    .trap_valid_i(trap32_v), .trap_pc_i(trap32_pc),
    .halt_i(halt32), .retire_i(retire32), .misalign_o(misalign32),
    .cycle_o(cycle32), .instret_o(instret32), .state_o(state32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic        mis;
    logic [1:0]  st;
    logic [63:0] cyc;
    logic [63:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [63:0] m_pc, m_cyc, m_ins;
  logic [1:0]  m_st;
  logic        m_valid, m_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h8000_0000; m_st = 2'd0; m_valid = 1'b0; m_mis = 1'b0;
    m_cyc = '0; m_ins = '0;
  endtask

  task automatic model_next(input logic rdy, rv, input logic [63:0] rpc,
                            input logic tv, input logic [63:0] tpc, input logic hlt, ret);
    m_mis = 1'b0;
    if (m_st == 2'd0) begin
      if (tv) m_pc = tpc & ~64'h3;
      m_st = 2'd1;
    end else if (m_st == 2'd1) begin
      if (tv) m_pc = tpc & ~64'h3;
      else if (rv) begin
        if (rpc[1:0] == 2'b00) m_pc = rpc;
        else                   m_mis = 1'b1;
        if (hlt) m_st = 2'd2;
      end else if (hlt) m_st = 2'd2;
      else if (rdy) m_pc = m_pc + 64'd4;
    end else begin
      if (tv) begin
        m_pc = tpc & ~64'h3;
        m_st = 2'd1;
      end else if (!hlt) m_st = 2'd1;
    end
    m_valid = (m_st == 2'd1);
    m_cyc = m_cyc + 64'd1;
    if (ret) m_ins = m_ins + 64'd1;
  endtask

  task automatic step(input logic rdy, rv, input logic [63:0] rpc,
                      input logic tv, input logic [63:0] tpc, input logic hlt, ret);
    exp_t e;
    @(negedge clk);
    fif.fetch_ready_i = rdy; red_v = rv; red_pc = rpc;
    trap_v = tv; trap_pc = tpc; halt = hlt; retire = ret;
    model_next(rdy, rv, rpc, tv, tpc, hlt, ret);
    e = '{pc: m_pc, valid: m_valid, mis: m_mis, st: m_st, cyc: m_cyc, ins: m_ins};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc", fif.pc_o, e.pc);
    check("valid", {63'd0, fif.fetch_valid_o}, {63'd0, e.valid});
    check("misalign", {63'd0, misalign}, {63'd0, e.mis});
    check("state", {62'd0, state}, {62'd0, e.st});
    check("cycle", cycle, e.cyc);
    check("instret", instret, e.ins);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, fif.pc_o, 64'h8000_0000);
    check({tag, "_valid"}, {63'd0, fif.fetch_valid_o}, 64'd0);
    check({tag, "_mis"}, {63'd0, misalign}, 64'd0);
    check({tag, "_state"}, {62'd0, state}, 64'd0);
    check({tag, "_cycle"}, cycle, 64'd0);
    check({tag, "_instret"}, instret, 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; rst32_n = 1'b0;
    fif.fetch_ready_i = 1'b0; red_v = 1'b0; red_pc = '0; trap_v = 1'b0; trap_pc = '0;
    halt = 1'b0; retire = 1'b0;
    fif32.fetch_ready_i = 1'b0; red32_v = 1'b0; red32_pc = '0; trap32_v = 1'b0;
    trap32_pc = '0; halt32 = 1'b0; retire32 = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    release_reset();

    // boot then sequential fetch
    step(1, 0, 0, 0, 0, 0, 1);
    check("seq1", fif.pc_o, 64'h8000_0000);
    step(1, 0, 0, 0, 0, 0, 1);
    check("seq2", fif.pc_o, 64'h8000_0004);
    step(1, 0, 0, 0, 0, 0, 0);
    check("seq3", fif.pc_o, 64'h8000_0008);

    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    check("stall_hold", fif.pc_o, 64'h8000_0008);
    step(0, 1, 64'h8000_1000, 0, 0, 0, 0);
    check("redir_noready", fif.pc_o, 64'h8000_1000);

    step(1, 1, 64'h8000_2000, 1, 64'h8000_0103, 0, 1);
    check("trap_pc", fif.pc_o, 64'h8000_0100);
    check("trap_mis", {63'd0, misalign}, 64'd0);

    step(1, 1, 64'h8000_0006, 0, 0, 0, 0);
    check("mis_pc", fif.pc_o, 64'h8000_0100);
    check("mis_pulse", {63'd0, misalign}, 64'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("mis_clear", {63'd0, misalign}, 64'd0);

    repeat (3) step(1, 0, 0, 0, 0, 1, 0);
    check("halt_state", {62'd0, state}, 64'd2);
    check("halt_pc", fif.pc_o, 64'h8000_0100);
    step(1, 0, 0, 0, 0, 0, 0);
    check("unhalt_pc", fif.pc_o, 64'h8000_0100);

    // halt with simultaneous redirect, ignored redirects in HALT, trap out of HALT
    step(1, 1, 64'h8000_3000, 0, 0, 1, 0);
    step(1, 1, 64'h8000_4001, 0, 0, 1, 0);
    step(1, 1, 64'h8000_5000, 0, 0, 1, 0);
    step(1, 0, 0, 1, 64'h8000_0202, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [63:0] rp;
      rp = {32'h0, $urandom};
      if ($urandom_range(0, 2) != 0) rp[1:0] = 2'b00;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rp,
           $urandom_range(0, 15) == 0, {32'h0, $urandom},
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
    end

    // asynchronous reset mid-HALT
    repeat (2) step(1, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    release_reset();
    step(1, 1, 64'h8000_0006, 0, 0, 0, 0);
    check("boot_redir_ign", {63'd0, misalign}, 64'd0);
    step(1, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    release_reset();
    step(1, 0, 0, 1, 64'h8000_0407, 0, 0);
    check("boot_trap", fif.pc_o, 64'h8000_0404);

    // 32-bit pc wrap and 4-bit counter wrap
    @(posedge clk);
    #1;
    rst32_n = 1'b1;
    fif32.fetch_ready_i = 1'b1;
    retire32 = 1'b1;
    @(posedge clk);
    #1;
    check("w32_boot_pc", {32'd0, fif32.pc_o}, 64'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check("w32_pc_wrap", {32'd0, fif32.pc_o}, 64'h0);
    fif32.fetch_ready_i = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("w32_cyc15", {60'd0, cycle32}, 64'd15);
    check("w32_ins15", {60'd0, instret32}, 64'd15);
    @(posedge clk);
    #1;
    check("w32_cyc_wrap", {60'd0, cycle32}, 64'd0);
    check("w32_ins_wrap", {60'd0, instret32}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 64, width of the program counter and its targets.
REQ-002 SHALL provide parameter RESET_VEC, default 64'h8000_0000, PC value loaded on reset.
REQ-003 SHALL provide parameter CNT_W, default 64, width of the cycle and instret counters.
REQ-004 SHALL provide port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL provide port fetch_valid_o  output  1  pc_o is a valid fetch address.
REQ-007 SHALL provide port fetch_ready_i  input  1  fetch stage accepts pc_o.
REQ-008 SHALL provide port pc_o  output  XLEN  current fetch PC.
REQ-009 SHALL provide port redirect_valid_i  input  1  branch/jump taken.
REQ-010 SHALL provide port redirect_pc_i  input  XLEN  branch/jump target.
REQ-011 SHALL provide port trap_valid_i  input  1  trap taken.
REQ-012 SHALL provide port trap_pc_i  input  XLEN  trap vector.
REQ-013 SHALL provide port halt_i  input  1  halt request, level-sensitive.
REQ-014 SHALL provide port retire_i  input  1  one instruction retired this cycle.
REQ-015 SHALL provide port misalign_o  output  1  one-cycle pulse on rejected misaligned redirect.
REQ-016 SHALL provide ports cycle_o and instret_o  output  CNT_W  free-running counters.
REQ-017 SHALL provide port state_o  output  2  current FSM state encoding.

Function
REQ-018 SHALL implement FSM states BOOT=0, RUN=1, HALT=2; encoding 3 unused and recovers to BOOT.
REQ-019 BOOT SHALL last exactly one cycle with fetch_valid_o=0, then go to RUN, unless trap_valid_i is asserted, which takes the trap in the same cycle.
REQ-020 In RUN, fetch_valid_o SHALL be 1; in BOOT and HALT it SHALL be 0.
REQ-021 A handshake is fetch_valid_o & fetch_ready_i; on a handshake with no redirect or trap, pc SHALL become pc+4 next cycle, modulo 2^XLEN.
REQ-022 While fetch_valid_o=1 and fetch_ready_i=0 with no redirect or trap, pc_o SHALL be held stable.
REQ-023 Next-PC priority SHALL be: trap > redirect > sequential > hold.
REQ-024 A trap SHALL load trap_pc_i with bits [1:0] forced to 0, in any state, and move the FSM to RUN.
REQ-025 In RUN, a redirect SHALL load redirect_pc_i next cycle, independent of fetch_ready_i, if redirect_pc_i[1:0]==0.
REQ-026 A redirect with redirect_pc_i[1:0]!=0 SHALL leave pc unchanged and assert misalign_o for exactly that following cycle.
REQ-027 A redirect in BOOT or HALT SHALL be ignored, with no misalign_o pulse.
REQ-028 In RUN with halt_i=1 and no trap, the FSM SHALL go to HALT next cycle.
  - A simultaneous redirect is still applied.
  - Otherwise pc SHALL hold; a sequential advance is not taken.
REQ-029 In HALT with halt_i=0, the FSM SHALL return to RUN, and pc_o SHALL be unchanged.
REQ-030 cycle_o SHALL increment every cycle outside reset and wrap modulo 2^CNT_W.
REQ-031 instret_o SHALL increment on retire_i in any state and wrap modulo 2^CNT_W.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 While rst_ni=0, the block SHALL asynchronously apply pc_o=RESET_VEC, state=BOOT, fetch_valid_o=0, misalign_o=0, cycle_o=0, instret_o=0.
REQ-034 Reset asserted mid-operation SHALL abandon any pending redirect, trap or halt.
REQ-035 The first rising edge after rst_ni rises SHALL be a BOOT cycle.

Structure
REQ-036 The state enum and ILEN_BYTES=4 SHALL live in shared package core_pkg.
REQ-037 The two counters SHALL be one sub-module instantiated twice: wrap_counter (parameter W; ports clk_i, rst_ni, inc_i, cnt_o).

Verification
REQ-038 Reset release, then fetch_ready_i=1 for 3 cycles -> pc_o sequence 0x80000000 (BOOT, valid=0), 0x80000000, 0x80000004, 0x80000008.
REQ-039 fetch_ready_i=0 for 4 cycles in RUN -> pc_o stable; then redirect 0x80001000 with ready=0 -> pc_o=0x80001000 next cycle.
REQ-040 Trap 0x80000103 with a simultaneous redirect 0x80002000 -> pc_o=0x80000100 and misalign_o=0.
REQ-041 Redirect 0x80000006 -> pc_o unchanged and misalign_o=1 for exactly one cycle.
REQ-042 XLEN=32, pc=0xFFFFFFFC, one handshake -> pc_o=0x00000000; CNT_W=4 -> cycle_o wraps 15 to 0.
REQ-043 halt_i=1 for 3 cycles -> state HALT, fetch_valid_o=0, pc_o held; then release -> RUN at the same pc; rst_ni pulsed mid-HALT -> all outputs at reset values immediately.
